// File: rtl/uart_rx_param.sv
// uart_rx_param: 16x-oversampled UART receiver with 3-sample majority vote and ready/valid output.
// Define RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FWFT FIFO.
module uart_rx_param #(
    parameter int CLOCK_HZ   = 50000000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [2:0]           baud_select,
    input  logic                 Rx_EN,
    input  logic                 RxD,
    input  logic                 Rx_READY,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR,
    output logic                 Rx_OVERRUN,
    output logic                 Rx_BUSY
);
    function automatic int div_of(input int baud);
        int d;
        d = (CLOCK_HZ + 8 * baud) / (16 * baud);
        return d < 1 ? 1 : d;
    endfunction

    localparam int DIVS [8] = '{div_of(300), div_of(1200), div_of(4800), div_of(9600),
                                div_of(19200), div_of(38400), div_of(57600), div_of(115200)};
    localparam int CW = $clog2(DIVS[0] + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_DONE} state_t;

    state_t               state;
    logic                 rx_s1, rx_s2;
    logic [2:0]           baud_q;
    logic [CW-1:0]        cnt, div_m1;
    logic                 tick, clr, start_det, maj, deliver;
    logic [3:0]           tcnt, bcnt;
    logic                 scnt, bit_q, perr, ferr;
    logic [1:0]           v;
    logic [DATA_BITS-1:0] sh;

    assign div_m1    = CW'(DIVS[baud_select] - 1);
    assign start_det = state == S_IDLE && Rx_EN && !rx_s2;
    assign clr       = !Rx_EN || baud_q != baud_select || start_det;
    assign tick      = !clr && cnt == div_m1;
    assign maj       = (v[0] & v[1]) | (v[0] & rx_s2) | (v[1] & rx_s2);
    assign deliver   = state == S_DONE && Rx_EN;
    assign Rx_BUSY   = state != S_IDLE;

    always_ff @(posedge clock) begin
        baud_q <= baud_select;
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            cnt   <= '0;
        end else begin
            rx_s1 <= RxD;
            rx_s2 <= rx_s1;
            cnt   <= (clr || tick) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            tcnt  <= '0;
            bcnt  <= '0;
            scnt  <= 1'b0;
            v     <= '0;
            bit_q <= 1'b0;
            sh    <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
        end else if (!Rx_EN) begin
            state <= S_IDLE;
        end else if (state == S_IDLE) begin
            if (start_det) begin
                state <= S_START;
                tcnt  <= '0;
            end
        end else if (state == S_DONE) begin
            state <= S_IDLE;
        end else if (tick) begin
            tcnt <= tcnt + 4'd1;
            if (tcnt == 4'd7) v[0] <= rx_s2;
            if (tcnt == 4'd8) v[1] <= rx_s2;
            if (tcnt == 4'd9) bit_q <= maj;
            case (state)
                S_START: begin
                    if (tcnt == 4'd9 && maj) state <= S_IDLE;
                    else if (tcnt == 4'd15) begin
                        state <= S_DATA;
                        bcnt  <= '0;
                        scnt  <= 1'b0;
                        perr  <= 1'b0;
                        ferr  <= 1'b0;
                    end
                end
                S_DATA: if (tcnt == 4'd15) begin
                    sh   <= {bit_q, sh[DATA_BITS-1:1]};
                    bcnt <= bcnt + 4'd1;
                    if (bcnt == 4'(DATA_BITS - 1)) state <= PARITY == 0 ? S_STOP : S_PAR;
                end
                S_PAR: if (tcnt == 4'd15) begin
                    perr  <= bit_q ^ (^sh) ^ (PARITY == 2);
                    state <= S_STOP;
                end
                // the last stop bit ends at its vote so a following start edge is caught on time
                S_STOP: begin
                    if (tcnt == 4'd9) begin
                        ferr <= ferr | !maj;
                        if (scnt == 1'(STOP_BITS - 1)) state <= S_DONE;
                    end else if (tcnt == 4'd15) scnt <= scnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wp, rp;
    logic                 empty, full, pop;

    assign empty    = wp == rp;
    assign full     = wp == {~rp[AW], rp[AW-1:0]};
    assign pop      = !empty && Rx_READY;
    assign Rx_VALID = !empty;
    assign {Rx_DATA, Rx_PERROR, Rx_FERROR} = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wp         <= '0;
            rp         <= '0;
            Rx_OVERRUN <= 1'b0;
        end else begin
            if (deliver && (!full || pop)) begin
                mem[wp[AW-1:0]] <= {sh, perr, ferr};
                wp              <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            Rx_OVERRUN <= (deliver && full && !pop) || (Rx_OVERRUN && !pop);
        end
    end
`else
    logic accept;
    assign accept = Rx_VALID && Rx_READY;

    always_ff @(posedge clock) begin
        if (reset) begin
            Rx_DATA    <= '0;
            Rx_VALID   <= 1'b0;
            Rx_PERROR  <= 1'b0;
            Rx_FERROR  <= 1'b0;
            Rx_OVERRUN <= 1'b0;
        end else begin
            Rx_VALID   <= deliver || (Rx_VALID && !accept);
            Rx_OVERRUN <= (deliver && Rx_VALID && !accept) || (Rx_OVERRUN && !accept);
            if (deliver) begin
                Rx_DATA   <= sh;
                Rx_PERROR <= perr;
                Rx_FERROR <= ferr;
            end
        end
    end
`endif
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frame vectors plus hand-written overrun, false-start, enable and reset sequences.
module tb_uart_rx_param;
    logic       clk = 1'b0;
    logic       reset, Rx_EN, RxD, Rx_READY;
    logic [2:0] baud_select;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_OVERRUN, Rx_BUSY;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLOCK_HZ(1843200), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut (
        .clock(clk), .reset(reset), .baud_select(baud_select), .Rx_EN(Rx_EN), .RxD(RxD),
        .Rx_READY(Rx_READY), .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR),
        .Rx_FERROR(Rx_FERROR), .Rx_OVERRUN(Rx_OVERRUN), .Rx_BUSY(Rx_BUSY)
    );

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
    } vec_t;

    vec_t       vt [7];
    int         total = 0, passed = 0;
    int         vcyc = 0, nacc = 0;
    int         v0, a0, k;
    logic [7:0] last_d = '0;
    logic       last_p = 1'b0, last_f = 1'b0;

    always @(negedge clk) begin
        if (Rx_VALID) vcyc++;
        if (Rx_VALID && Rx_READY) begin
            nacc++;
            last_d = Rx_DATA;
            last_p = Rx_PERROR;
            last_f = Rx_FERROR;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // mode 0: whole frame; 1: drop Rx_EN mid data bit 3; 2: pulse reset mid data bit 3 and idle the line
    task automatic send(input logic [7:0] d, input logic p, input logic s, input int mode);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int n = 0; n < 11; n++) begin
            RxD = f[n];
            if (n == 4 && mode == 2) begin
                cyc(8);
                reset = 1'b1;
                RxD   = 1'b1;
                cyc(1);
                reset = 1'b0;
                return;
            end
            if (n == 4 && mode == 1) begin
                cyc(8);
                Rx_EN = 1'b0;
                cyc(8);
            end else cyc(16);
        end
        RxD = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vt[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vt[3] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vt[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vt[5] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
        vt[6] = '{8'h0F, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1};

        reset = 1'b1; RxD = 1'b1; Rx_EN = 1'b1; Rx_READY = 1'b1; baud_select = 3'd7;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        check("rst_data", Rx_DATA, 0);
        check("rst_valid", Rx_VALID, 0);
        check("rst_perr", Rx_PERROR, 0);
        check("rst_ferr", Rx_FERROR, 0);
        check("rst_overrun", Rx_OVERRUN, 0);
        check("rst_busy", Rx_BUSY, 0);

        for (int i = 0; i < 7; i++) begin
            v0 = vcyc; a0 = nacc;
            send(vt[i].d, vt[i].p, vt[i].s, 0);
            cyc(30);
            check($sformatf("vec%0d_valid_cycles", i), vcyc - v0, 1);
            check($sformatf("vec%0d_accepts", i), nacc - a0, 1);
            check($sformatf("vec%0d_data", i), last_d, vt[i].ed);
            check($sformatf("vec%0d_perr", i), last_p, vt[i].ep);
            check($sformatf("vec%0d_ferr", i), last_f, vt[i].ef);
            check($sformatf("vec%0d_overrun", i), Rx_OVERRUN, 0);
            check($sformatf("vec%0d_busy", i), Rx_BUSY, 0);
        end

        v0 = vcyc;
        RxD = 1'b0;
        cyc(4);
        RxD = 1'b1;
        cyc(1);
        check("fs_busy_started", Rx_BUSY, 1);
        k = 0;
        while (Rx_BUSY && k < 10) begin
            cyc(1);
            k++;
        end
        check("fs_busy_cleared", Rx_BUSY, 0);
        cyc(20);
        check("fs_no_valid", vcyc - v0, 0);

        Rx_READY = 1'b0;
`ifdef RX_FIFO_EN
        for (int i = 1; i <= 5; i++) begin
            send(8'(i), ^8'(i), 1'b1, 0);
            cyc(20);
        end
        check("fifo_overrun", Rx_OVERRUN, 1);
        check("fifo_valid", Rx_VALID, 1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("fifo_head%0d", i), Rx_DATA, i);
            check($sformatf("fifo_ovr%0d", i), Rx_OVERRUN, i == 1 ? 1 : 0);
            Rx_READY = 1'b1;
            cyc(1);
            Rx_READY = 1'b0;
        end
        check("fifo_empty", Rx_VALID, 0);
        check("fifo_ovr_clear", Rx_OVERRUN, 0);
`else
        send(8'h11, 1'b0, 1'b1, 0);
        cyc(20);
        check("ovr_first_valid", Rx_VALID, 1);
        check("ovr_first_data", Rx_DATA, 8'h11);
        check("ovr_first_flag", Rx_OVERRUN, 0);
        send(8'h22, 1'b0, 1'b1, 0);
        cyc(20);
        check("ovr_second_valid", Rx_VALID, 1);
        check("ovr_second_data", Rx_DATA, 8'h22);
        check("ovr_second_flag", Rx_OVERRUN, 1);
        Rx_READY = 1'b1;
        cyc(1);
        Rx_READY = 1'b0;
        check("ovr_accept_valid", Rx_VALID, 0);
        check("ovr_accept_flag", Rx_OVERRUN, 0);
`endif

        send(8'h07, 1'b1, 1'b1, 0);
        cyc(20);
        check("en_pending_valid", Rx_VALID, 1);
        check("en_pending_data", Rx_DATA, 8'h07);
        a0 = nacc;
        send(8'h55, 1'b0, 1'b1, 1);
        cyc(20);
        check("en_valid_held", Rx_VALID, 1);
        check("en_data_held", Rx_DATA, 8'h07);
        check("en_busy", Rx_BUSY, 0);
        check("en_overrun", Rx_OVERRUN, 0);
        Rx_EN = 1'b1;
        Rx_READY = 1'b1;
        cyc(2);
        check("en_drain_accepts", nacc - a0, 1);
        check("en_drain_valid", Rx_VALID, 0);

        v0 = vcyc;
        send(8'h55, 1'b0, 1'b1, 2);
        cyc(20);
        check("rstmid_no_valid", vcyc - v0, 0);
        check("rstmid_busy", Rx_BUSY, 0);
        check("rstmid_data", Rx_DATA, 0);

        a0 = nacc;
        send(8'h66, 1'b0, 1'b1, 0);
        cyc(30);
        check("clean_accepts", nacc - a0, 1);
        check("clean_data", last_d, 8'h66);
        check("clean_perr", last_p, 0);
        check("clean_ferr", last_f, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
